multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Multi-cycle sequencing FSM for the RV32I core. Drives fetch, decode, execute,
//  memory and write-back around the instruction decoder, ALU, register file and PC.
//  Issues the instruction and data memory handshakes, plus PC, IR and register-file
//  write strobes. Counts retired instructions and traps on illegal opcodes or memory timeouts.
// PARAMETERS
//  CNT_W    32   width of the retired-instruction counter (wraps at 2^CNT_W)
//  TMO_MAX  255  cycles a memory request may wait for ack before a timeout trap (>=1)
// PORTS
//  clk         in   1      system clock, rising edge
//  rst_n       in   1      asynchronous, active-low reset
//  ins_op      in   7      opcode field ins[6:0] from decoder
//  ins_subop   in   3      funct3 ins[14:12] from decoder
//  br_taken    in   1      branch comparator result, valid in EXEC
//  imem_ack    in   1      instruction memory ack; instr valid on ack cycle
//  dmem_ack    in   1      data memory ack; load data valid on ack cycle
//  imem_req    out  1      instruction fetch request
//  dmem_req    out  1      data access request
//  dmem_we     out  1      1=store, 0=load; valid while dmem_req=1
//  ir_we       out  1      load instruction register (1-cycle pulse)
//  pc_we       out  1      update PC (1-cycle pulse)
//  pc_sel      out  2      00 pc+4, 01 pc+imm (branch/JAL), 10 rs1+imm (JALR)
//  reg_we      out  1      register file write enable (1-cycle pulse)
//  wb_sel      out  2      00 ALU result, 01 load data, 10 pc+4
//  trap        out  1      sticky; core halted
//  trap_cause  out  2      00 none, 01 illegal opcode, 10 imem timeout, 11 dmem timeout
//  state_o     out  3      current state encoding (debug)
//  retired     out  CNT_W  retired instruction count
// BEHAVIOUR
//  States: IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 TRAP=6. All regs on posedge clk.
//  Reset (rst_n=0, async): state=IDLE, retired=0, trap=0, trap_cause=0, timeout cnt=0.
//   All outputs are 0 (state_o=0) while in reset.
//  Outputs are Moore-decoded from registered state and latched opcode. No comb path from ins_op.
//  IDLE: always -> FETCH next cycle.
//  FETCH: imem_req=1. On imem_ack: ir_we=1 same cycle -> DECODE.
//  DECODE: latch ins_op/ins_subop. Legal opcodes: 0000011 0100011 0110011 0010011
//   0010111 0110111 1101111 1100111 1100011. Illegal -> TRAP, cause 01; else -> EXEC.
//  EXEC: LOAD/STORE -> MEM.
//   BRANCH: pc_we=1, pc_sel=br_taken?01:00, retire -> FETCH.
//   All others -> WB.
//  MEM: dmem_req=1, dmem_we=(op==STORE).
//   On dmem_ack: load -> WB; store -> FETCH with pc_we=1, pc_sel=00, retire.
//  WB: reg_we=1, pc_we=1, retire -> FETCH.
//   wb_sel=01 for LOAD, 10 for JAL/JALR, else 00.
//   pc_sel=01 JAL, 10 JALR, else 00.
//  Retire: retired+=1 on every cycle with pc_we=1. Wraps to 0 silently.
//  Handshake: req held high until ack sampled high; req drops the cycle after ack.
//   ack with req=0 is ignored.
//  Timeout: counter clears on entry to FETCH/MEM and increments each waiting cycle.
//   At TMO_MAX cycles without ack -> TRAP, cause 10 (FETCH) or 11 (MEM).
//   Ack on the same cycle as the limit wins; no trap.
//  TRAP: all strobes and reqs 0; trap=1; exit only via rst_n.
//  Reset mid-request: req drops asynchronously; a late ack after reset is ignored (IDLE).
// TESTING
//  ADDI: ack fetch in 1 cycle -> states 1,2,3,5,1; reg_we, pc_we in WB; wb_sel=00; retired=1.
//  LW with dmem_ack after 3 cycles -> dmem_req high 3 cycles, dmem_we=0, then WB wb_sel=01.
//  SW -> dmem_we=1 in MEM; no reg_we; pc_we on ack cycle; BEQ taken -> pc_sel=01 in EXEC, no WB.
//  JALR -> WB with wb_sel=10, pc_sel=10; JAL -> pc_sel=01; retired increments by 1 each.
//  ins_op=7'b1111111 -> TRAP, trap_cause=01, no further imem_req until rst_n pulse.
//  TMO_MAX=4, imem_ack stuck 0 -> trap after 4 FETCH cycles, cause 10; rst_n low mid-MEM -> IDLE.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Instruction- and data-memory handshake bundle between the sequencer and memory.
// The controller drives requests; memory answers with a one-cycle ack.
interface multicycle_ctrl_if;
    logic imem_req;
    logic imem_ack;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ack;

    modport master (output imem_req, dmem_req, dmem_we, input imem_ack, dmem_ack);
    modport slave  (input imem_req, dmem_req, dmem_we, output imem_ack, dmem_ack);
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: fetch/decode/exec/mem/writeback with memory handshakes,
// retired-instruction counting and sticky traps on illegal opcodes or memory timeouts.
module multicycle_ctrl #(
    parameter int CNT_W   = 32,
    parameter int TMO_MAX = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           ins_op,
    input  logic [2:0]           ins_subop,
    input  logic                 br_taken,
    multicycle_ctrl_if.master    mem,
    output logic                 ir_we,
    output logic                 pc_we,
    output logic [1:0]           pc_sel,
    output logic                 reg_we,
    output logic [1:0]           wb_sel,
    output logic                 trap,
    output logic [1:0]           trap_cause,
    output logic [2:0]           state_o,
    output logic [CNT_W-1:0]     retired
);
    localparam int TMO_W = (TMO_MAX > 1) ? $clog2(TMO_MAX) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_MAX - 1);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'b00,
        CAUSE_ILLEGAL  = 2'b01,
        CAUSE_IMEM_TMO = 2'b10,
        CAUSE_DMEM_TMO = 2'b11
    } cause_e;

    state_e            state_q, state_d;
    cause_e            cause_q, cause_d;
    logic [6:0]        op_q;
    logic [2:0]        subop_q;
    logic [TMO_W-1:0]  tmo_q;
    logic [CNT_W-1:0]  retired_q;
    logic              waiting;
    logic              tmo_hit;
    logic              is_store;

    function automatic logic op_legal(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_STORE, OP_REG, OP_IMM, OP_AUIPC,
            OP_LUI, OP_JAL, OP_JALR, OP_BRANCH: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    assign waiting  = (state_q == S_FETCH && !mem.imem_ack) || (state_q == S_MEM && !mem.dmem_ack);
    assign tmo_hit  = (tmo_q == TMO_LAST);
    assign is_store = (op_q == OP_STORE);

    // NOTE: state and counters use non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cause_q <= CAUSE_NONE;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
        end
    end

    // funct3 is captured alongside the opcode for the ALU-control path; sequencing ignores it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= '0;
            subop_q   <= '0;
            tmo_q     <= '0;
            retired_q <= '0;
        end else begin
            if (state_q == S_DECODE) begin
                op_q    <= ins_op;
                subop_q <= ins_subop;
            end
            // Clearing whenever not waiting guarantees a fresh count on every FETCH/MEM entry.
            tmo_q <= waiting ? tmo_q + TMO_W'(1) : '0;
            if (pc_we) retired_q <= retired_q + CNT_W'(1);
        end
    end

    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        unique case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH: begin
                if (mem.imem_ack)  state_d = S_DECODE;
                else if (tmo_hit) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_IMEM_TMO;
                end
            end
            S_DECODE: begin
                if (op_legal(ins_op)) state_d = S_EXEC;
                else begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end
            end
            S_EXEC: begin
                if (op_q == OP_LOAD || op_q == OP_STORE) state_d = S_MEM;
                else if (op_q == OP_BRANCH)              state_d = S_FETCH;
                else                                     state_d = S_WB;
            end
            S_MEM: begin
                if (mem.dmem_ack)  state_d = is_store ? S_FETCH : S_WB;
                else if (tmo_hit) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_DMEM_TMO;
                end
            end
            S_WB:     state_d = S_FETCH;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem.imem_req = 1'b0;
        mem.dmem_req = 1'b0;
        mem.dmem_we  = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_sel       = 2'b00;
        reg_we       = 1'b0;
        wb_sel       = 2'b00;
        trap         = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem.imem_req = 1'b1;
                ir_we        = mem.imem_ack;
            end
            S_EXEC: begin
                if (op_q == OP_BRANCH) begin
                    pc_we  = 1'b1;
                    pc_sel = br_taken ? 2'b01 : 2'b00;
                end
            end
            S_MEM: begin
                mem.dmem_req = 1'b1;
                mem.dmem_we  = is_store;
                pc_we        = is_store && mem.dmem_ack;
            end
            S_WB: begin
                reg_we = 1'b1;
                pc_we  = 1'b1;
                if (op_q == OP_LOAD)                         wb_sel = 2'b01;
                else if (op_q == OP_JAL || op_q == OP_JALR) wb_sel = 2'b10;
                if (op_q == OP_JAL)       pc_sel = 2'b01;
                else if (op_q == OP_JALR) pc_sel = 2'b10;
            end
            S_TRAP:  trap = 1'b1;
            default: ;
        endcase
    end

    logic unused_subop;
    assign unused_subop = ^subop_q;

    assign trap_cause = cause_q;
    assign state_o    = state_q;
    assign retired    = retired_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: instruction walks, branch/jump selects, counter wrap,
// illegal-opcode trap, imem/dmem timeouts and reset in the middle of a memory request.
module tb_multicycle_ctrl;
    localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_EXEC = 3, S_MEM = 4, S_WB = 5, S_TRAP = 6;

    logic       clk;
    logic       rst_n;
    logic [6:0] ins_op;
    logic [2:0] ins_subop;
    logic       br_taken;
    logic       ir_we, pc_we, reg_we, trap;
    logic [1:0] pc_sel, wb_sel, trap_cause;
    logic [2:0] state_o;
    logic [2:0] retired;

    int n_checks = 0;
    int n_errors = 0;

    multicycle_ctrl_if bus ();

    multicycle_ctrl #(.CNT_W(3), .TMO_MAX(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ins_op     (ins_op),
        .ins_subop  (ins_subop),
        .br_taken   (br_taken),
        .mem        (bus),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .pc_sel     (pc_sel),
        .reg_we     (reg_we),
        .wb_sel     (wb_sel),
        .trap       (trap),
        .trap_cause (trap_cause),
        .state_o    (state_o),
        .retired    (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Starts in FETCH; ends one edge after DECODE (EXEC or TRAP).
    task automatic fetch(input logic [6:0] op, input int waits);
        for (int i = 0; i < waits; i++) begin
            bus.imem_ack = 1'b0;
            #1;
            check("fetch_wait_state", state_o, S_FETCH);
            check("fetch_wait_req", bus.imem_req, 1);
            check("fetch_wait_ir_we", ir_we, 0);
            step();
        end
        ins_op       = op;
        bus.imem_ack = 1'b1;
        #1;
        check("fetch_ir_we", ir_we, 1);
        step();
        bus.imem_ack = 1'b0;
        #1;
        check("decode_state", state_o, S_DECODE);
        check("decode_req_drop", bus.imem_req, 0);
        step();
    endtask

    task automatic wb_phase(input logic [1:0] exp_wb, input logic [1:0] exp_pc, input logic [2:0] exp_ret);
        #1;
        check("wb_state", state_o, S_WB);
        check("wb_reg_we", reg_we, 1);
        check("wb_pc_we", pc_we, 1);
        check("wb_sel", wb_sel, exp_wb);
        check("wb_pc_sel", pc_sel, exp_pc);
        step();
        #1;
        check("post_wb_state", state_o, S_FETCH);
        check("retired", retired, exp_ret);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_state", state_o, S_IDLE);
        check("rst_trap", trap, 0);
        check("rst_cause", trap_cause, 0);
        check("rst_retired", retired, 0);
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        rst_n        = 1'b0;
        ins_op       = '0;
        ins_subop    = '0;
        br_taken     = 1'b0;
        bus.imem_ack = 1'b1;
        bus.dmem_ack = 1'b1;
        repeat (2) step();
        check("reset_state", state_o, S_IDLE);
        check("reset_imem_req", bus.imem_req, 0);
        check("reset_dmem_req", bus.dmem_req, 0);
        check("reset_ir_we", ir_we, 0);
        check("reset_pc_we", pc_we, 0);
        check("reset_trap", trap, 0);
        check("reset_retired", retired, 0);
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
        rst_n        = 1'b1;
        #1;
        check("idle_state", state_o, S_IDLE);
        step();

        // ADDI: 1,2,3,5,1
        fetch(7'b0010011, 0);
        #1;
        check("addi_exec", state_o, S_EXEC);
        check("addi_exec_reg_we", reg_we, 0);
        check("addi_exec_pc_we", pc_we, 0);
        step();
        wb_phase(2'b00, 2'b00, 3'd1);

        // LW, dmem ack on third MEM cycle
        fetch(7'b0000011, 0);
        step();
        for (int i = 0; i < 3; i++) begin
            bus.dmem_ack = (i == 2);
            #1;
            check("lw_mem_state", state_o, S_MEM);
            check("lw_dmem_req", bus.dmem_req, 1);
            check("lw_dmem_we", bus.dmem_we, 0);
            check("lw_pc_we", pc_we, 0);
            step();
        end
        bus.dmem_ack = 1'b0;
        #1;
        check("lw_req_drop", bus.dmem_req, 0);
        wb_phase(2'b01, 2'b00, 3'd2);

        // SW, ack exactly at the timeout limit: ack wins
        fetch(7'b0100011, 0);
        step();
        for (int i = 0; i < 4; i++) begin
            bus.dmem_ack = (i == 3);
            #1;
            check("sw_mem_state", state_o, S_MEM);
            check("sw_dmem_we", bus.dmem_we, 1);
            check("sw_reg_we", reg_we, 0);
            check("sw_pc_we", pc_we, (i == 3));
            check("sw_pc_sel", pc_sel, 0);
            step();
        end
        bus.dmem_ack = 1'b0;
        #1;
        check("sw_after_state", state_o, S_FETCH);
        check("sw_retired", retired, 3);
        check("sw_no_trap", trap, 0);

        // BEQ taken
        fetch(7'b1100011, 0);
        br_taken = 1'b1;
        #1;
        check("beq_exec", state_o, S_EXEC);
        check("beq_pc_we", pc_we, 1);
        check("beq_pc_sel", pc_sel, 1);
        check("beq_reg_we", reg_we, 0);
        step();
        br_taken = 1'b0;
        #1;
        check("beq_next_fetch", state_o, S_FETCH);
        check("beq_retired", retired, 4);

        // Branch not taken
        fetch(7'b1100011, 0);
        #1;
        check("bne_pc_we", pc_we, 1);
        check("bne_pc_sel", pc_sel, 0);
        step();
        #1;
        check("bne_retired", retired, 5);

        // JALR
        fetch(7'b1100111, 0);
        step();
        wb_phase(2'b10, 2'b10, 3'd6);

        // JAL, fetch ack exactly at the timeout limit
        fetch(7'b1101111, 3);
        step();
        wb_phase(2'b10, 2'b01, 3'd7);

        // LUI: retired counter wraps 7 -> 0
        fetch(7'b0110111, 0);
        step();
        wb_phase(2'b00, 2'b00, 3'd0);

        // Illegal opcode
        fetch(7'b1111111, 0);
        #1;
        check("ill_state", state_o, S_TRAP);
        check("ill_trap", trap, 1);
        check("ill_cause", trap_cause, 1);
        bus.imem_ack = 1'b1;
        repeat (3) step();
        check("ill_hold_state", state_o, S_TRAP);
        check("ill_no_req", bus.imem_req, 0);
        check("ill_no_ir_we", ir_we, 0);
        check("ill_retired", retired, 0);
        bus.imem_ack = 1'b0;
        do_reset();

        // imem timeout: 4 FETCH cycles then TRAP
        for (int i = 0; i < 4; i++) begin
            #1;
            check("itmo_state", state_o, S_FETCH);
            check("itmo_req", bus.imem_req, 1);
            step();
        end
        #1;
        check("itmo_trap_state", state_o, S_TRAP);
        check("itmo_cause", trap_cause, 2);
        check("itmo_req_off", bus.imem_req, 0);
        do_reset();

        // dmem timeout on a load
        fetch(7'b0000011, 0);
        step();
        for (int i = 0; i < 4; i++) begin
            #1;
            check("dtmo_state", state_o, S_MEM);
            step();
        end
        #1;
        check("dtmo_trap_state", state_o, S_TRAP);
        check("dtmo_cause", trap_cause, 3);
        check("dtmo_dmem_req", bus.dmem_req, 0);
        do_reset();

        // Reset asserted mid-MEM; late ack ignored
        fetch(7'b0000011, 0);
        step();
        step();
        #1;
        check("mid_mem_req", bus.dmem_req, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_req_drop", bus.dmem_req, 0);
        check("mid_rst_state", state_o, S_IDLE);
        bus.dmem_ack = 1'b1;
        step();
        rst_n = 1'b1;
        #1;
        check("late_ack_idle", state_o, S_IDLE);
        check("late_ack_pc_we", pc_we, 0);
        step();
        #1;
        check("late_ack_fetch", state_o, S_FETCH);
        check("late_ack_dmem_req", bus.dmem_req, 0);
        check("late_ack_retired", retired, 0);
        bus.dmem_ack = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
